data_mem_arb: RTL

- Parametrised next-generation PE data memory: two mirrored simple-dual-port arrays give two independent read ports (src1 and src2).
- Three write sources share one write port per array: sequential load, instruction-addressed ALU writeback, and sequential transfer into an upper region.
- Unlike the previous generation, colliding writebacks are queued rather than lost, transfer writes are back-pressured, and all widths and offsets are parameters.

---
 rtl/data_mem_arb_pkg.sv | 22 ++
 rtl/data_mem_arb_wb_queue.sv | 55 +++++
 rtl/data_mem_arb.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/data_mem_arb_pkg.sv
// Shared constants for data_mem_arb: default geometry, instruction field
// positions (in units of ADDR_W) and write-source encodings.
package data_mem_arb_pkg;
   localparam int DM_DATA_W    = 32;
   localparam int DM_ADDR_W    = 8;
   localparam int DM_INST_W    = 32;
   localparam int DM_WB_DELAY  = 4;
   localparam int DM_WBQ_DEPTH = 4;
   localparam logic [7:0] DM_XFER_BASE = 8'h8F;

   // inst = {src2, src1, dest} packed from the LSB, each ADDR_W wide
   localparam int FLD_DEST = 0;
   localparam int FLD_SRC1 = 1;
   localparam int FLD_SRC2 = 2;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_LOAD = 2'd1,
      SRC_WB   = 2'd2,
      SRC_XFER = 2'd3
   } wr_src_e;
endpackage

// File: rtl/data_mem_arb_wb_queue.sv
// Pending-writeback FIFO: holds {addr, data} entries; a push while full is
// ignored unless a pop happens in the same cycle.
module data_mem_arb_wb_queue #(
   parameter int W     = 40,
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push_i,
   input  logic                      pop_i,
   input  logic [W-1:0]              din_i,
   output logic [W-1:0]              dout_o,
   output logic                      full_o,
   output logic                      empty_o,
   output logic [$clog2(DEPTH):0]    level_o
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0]   LVL_FULL = (PW+1)'(DEPTH);
   localparam logic [PW:0]   LVL_ONE  = (PW+1)'(1);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PW:0]   level_q;
   logic          do_push_s, do_pop_s;

   assign empty_o   = (level_q == '0);
   assign full_o    = (level_q == LVL_FULL);
   assign do_pop_s  = pop_i && !empty_o;
   assign do_push_s = push_i && (!full_o || do_pop_s);
   assign dout_o    = mem_q[rd_ptr_q];
   assign level_o   = level_q;

   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push_s) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (do_pop_s)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         case ({do_push_s, do_pop_s})
            2'b10:   level_q <= level_q + LVL_ONE;
            2'b01:   level_q <= level_q - LVL_ONE;
            default: level_q <= level_q;
         endcase
      end
   end
endmodule

// File: rtl/data_mem_arb.sv
// PE data memory: two mirrored arrays, one arbitrated write port (load > writeback > transfer).
// Define DATA_MEM_BYPASS_EN for new-data read-during-write on the read ports.
module data_mem_arb
   import data_mem_arb_pkg::*;
#(
   parameter int DATA_W    = DM_DATA_W,
   parameter int ADDR_W    = DM_ADDR_W,
   parameter int INST_W    = DM_INST_W,
   parameter int WB_DELAY  = DM_WB_DELAY,
   parameter logic [ADDR_W-1:0] XFER_BASE = DM_XFER_BASE,
   parameter int WBQ_DEPTH = DM_WBQ_DEPTH
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        wea,
   input  logic [DATA_W-1:0]           dina,
   input  logic                        wben,
   input  logic                        web,
   input  logic [DATA_W-1:0]           dinb,
   output logic                        web_stall,
   input  logic                        inst_v,
   input  logic [INST_W-1:0]           inst,
   input  logic                        rden,
   output logic [DATA_W-1:0]           douta,
   output logic [DATA_W-1:0]           doutb,
   output logic [$clog2(WBQ_DEPTH):0]  wbq_level,
   output logic                        wb_ovf
);
   localparam int QW = ADDR_W + DATA_W;
   localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);

   logic [DATA_W-1:0] mem_a [2**ADDR_W];
   logic [DATA_W-1:0] mem_b [2**ADDR_W];

   logic [ADDR_W-1:0] load_ptr_q, xfer_ptr_q, xfer_ptr_d;
   logic [ADDR_W-1:0] raddra_q, raddrb_q, dest_q;
   logic [ADDR_W-1:0] dly_q [WB_DELAY];
   logic [DATA_W-1:0] douta_q, doutb_q, rd_a_s, rd_b_s;
   logic              wb_ovf_q;
   wr_src_e           wr_src_s;
   logic              we_s, q_push_s, q_pop_s, q_full_s, q_empty_s, drop_s;
   logic [ADDR_W-1:0] waddr_s, wb_addr_s;
   logic [DATA_W-1:0] wdata_s;
   logic [QW-1:0]     q_head_s;

   if (INST_W > 3*ADDR_W) begin : g_unused
      logic unused_inst_s;
      assign unused_inst_s = ^inst[INST_W-1:3*ADDR_W];
   end

   assign wb_addr_s = dly_q[WB_DELAY-1];
   assign drop_s    = q_push_s && q_full_s && !q_pop_s;
   assign douta     = douta_q;
   assign doutb     = doutb_q;
   assign wb_ovf    = wb_ovf_q;

   data_mem_arb_wb_queue #(.W(QW), .DEPTH(WBQ_DEPTH)) u_wbq (
      .clk     (clk),
      .rst     (rst),
      .push_i  (q_push_s),
      .pop_i   (q_pop_s),
      .din_i   ({wb_addr_s, dina}),
      .dout_o  (q_head_s),
      .full_o  (q_full_s),
      .empty_o (q_empty_s),
      .level_o (wbq_level)
   );

   // Pick this cycle's single writer; a new writeback queues behind loads and older entries.
   always_comb begin
      wr_src_s  = SRC_NONE;
      q_pop_s   = 1'b0;
      q_push_s  = 1'b0;
      web_stall = 1'b0;
      if (rst) begin
         wr_src_s = SRC_NONE;
      end else if (wea) begin
         wr_src_s  = SRC_LOAD;
         q_push_s  = wben;
         web_stall = web;
      end else if (!q_empty_s) begin
         wr_src_s  = SRC_WB;
         q_pop_s   = 1'b1;
         q_push_s  = wben;
         web_stall = web;
      end else if (wben) begin
         wr_src_s  = SRC_WB;
         web_stall = web;
      end else if (web) begin
         wr_src_s = SRC_XFER;
      end else begin
         wr_src_s = SRC_NONE;
      end
   end

   always_comb begin
      we_s    = 1'b1;
      waddr_s = '0;
      wdata_s = '0;
      case (wr_src_s)
         SRC_LOAD: begin
            waddr_s = load_ptr_q;
            wdata_s = dina;
         end
         SRC_WB: begin
            if (q_pop_s) begin
               waddr_s = q_head_s[QW-1:DATA_W];
               wdata_s = q_head_s[DATA_W-1:0];
            end else begin
               waddr_s = wb_addr_s;
               wdata_s = dina;
            end
         end
         SRC_XFER: begin
            waddr_s = xfer_ptr_q;
            wdata_s = dinb;
         end
         default: we_s = 1'b0;
      endcase
      xfer_ptr_d = (xfer_ptr_q == '1) ? XFER_BASE : xfer_ptr_q + A_ONE;
   end

   always_comb begin
`ifdef DATA_MEM_BYPASS_EN
      rd_a_s = (we_s && waddr_s == raddra_q) ? wdata_s : mem_a[raddra_q];
      rd_b_s = (we_s && waddr_s == raddrb_q) ? wdata_s : mem_b[raddrb_q];
`else
      rd_a_s = mem_a[raddra_q];
      rd_b_s = mem_b[raddrb_q];
`endif
   end

   always_ff @(posedge clk) begin
      if (we_s) begin
         mem_a[waddr_s] <= wdata_s;
         mem_b[waddr_s] <= wdata_s;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         load_ptr_q <= '0;
         xfer_ptr_q <= XFER_BASE;
         raddra_q   <= '0;
         raddrb_q   <= '0;
         dest_q     <= '0;
         for (int i = 0; i < WB_DELAY; i++) dly_q[i] <= '0;
         wb_ovf_q   <= 1'b0;
         douta_q    <= '0;
         doutb_q    <= '0;
      end else begin
         if (inst_v) begin
            raddrb_q <= inst[FLD_SRC2*ADDR_W +: ADDR_W];
            raddra_q <= inst[FLD_SRC1*ADDR_W +: ADDR_W];
            dest_q   <= inst[FLD_DEST*ADDR_W +: ADDR_W];
         end
         dly_q[0] <= dest_q;
         for (int i = 1; i < WB_DELAY; i++) dly_q[i] <= dly_q[i-1];
         if (wr_src_s == SRC_LOAD) load_ptr_q <= load_ptr_q + A_ONE;
         if (wr_src_s == SRC_XFER) xfer_ptr_q <= xfer_ptr_d;
         if (drop_s) wb_ovf_q <= 1'b1;
         if (rden) begin
            douta_q <= rd_a_s;
            doutb_q <= rd_b_s;
         end
      end
   end
endmodule
